// File: rtl/bp_be_pkg.sv
// bp_be_pkg: stride-detector table entry layout and trigger reasons
`ifndef BP_BE_STRIDE_ENTRY_MACROS
`define BP_BE_STRIDE_ENTRY_MACROS
`define DECLARE_BP_BE_STRIDE_ENTRY_S(vaddr_width_mp, tag_width_mp, conf_width_mp, loop_range_mp) \
  typedef struct packed { \
    logic v; \
    logic [tag_width_mp-1:0] tag; \
    logic [vaddr_width_mp-1:0] last_addr; \
    logic [vaddr_width_mp-1:0] stride; \
    logic [conf_width_mp-1:0] conf; \
    logic [loop_range_mp-1:0] quiet; \
  } bp_be_stride_entry_s
`define BP_BE_STRIDE_ENTRY_WIDTH(vaddr_width_mp, tag_width_mp, conf_width_mp, loop_range_mp) \
  (1 + (tag_width_mp) + 2*(vaddr_width_mp) + (conf_width_mp) + (loop_range_mp))
`endif

package bp_be_pkg;
  typedef enum logic [1:0] {
    e_stride_miss,
    e_stride_train,
    e_stride_quiet,
    e_stride_issue
  } bp_be_stride_reason_e;
endpackage

// File: rtl/bp_be_stride_entry_update.sv
// bp_be_stride_entry_update: next table entry and issue qualification for one observed load
module bp_be_stride_entry_update
  import bp_be_pkg::*;
#(
  parameter int vaddr_width_p = 39,
  parameter int tag_width_p = 33,
  parameter int stride_width_p = 8,
  parameter int conf_width_p = 2,
  parameter int conf_thresh_p = 2,
  parameter int loop_range_p = 8,
  parameter int prefetch_depth_p = 4,
  localparam int entry_width_lp = `BP_BE_STRIDE_ENTRY_WIDTH(vaddr_width_p, tag_width_p, conf_width_p, loop_range_p)
) (
  input  logic [entry_width_lp-1:0] entry_i,
  input  logic [tag_width_p-1:0]    tag_i,
  input  logic [vaddr_width_p-1:0]  addr_i,
  input  logic                      slot_free_i,
  output logic [entry_width_lp-1:0] entry_o,
  output logic                      trigger_o,
  output bp_be_stride_reason_e      reason_o
);
  `DECLARE_BP_BE_STRIDE_ENTRY_S(vaddr_width_p, tag_width_p, conf_width_p, loop_range_p);
  bp_be_stride_entry_s r, n;
  logic [vaddr_width_p-1:0] diff;
  logic [conf_width_p-1:0] conf_inc;
  logic hit, match, fit, qualify;
  assign r = entry_i;
  assign entry_o = n;
  assign diff = addr_i - r.last_addr;
  assign hit = r.v & (r.tag == tag_i);
  assign match = diff == r.stride;
  assign conf_inc = &r.conf ? r.conf : r.conf + 1'b1;
  // positive and narrow enough to travel in stride_o
  assign fit = (|diff) & ~|diff[vaddr_width_p-1:stride_width_p];
  assign qualify = hit & match & fit & (r.quiet == '0) & (conf_inc >= conf_width_p'(conf_thresh_p));
  assign trigger_o = qualify & slot_free_i;
  assign reason_o = !hit ? e_stride_miss
                  : qualify ? e_stride_issue
                  : (match && r.quiet != '0) ? e_stride_quiet
                  : e_stride_train;
  always_comb begin
    n = r;
    n.last_addr = addr_i;
    if (!hit) begin
      n.v = 1'b1;
      n.tag = tag_i;
      n.stride = '0;
      n.conf = '0;
      n.quiet = '0;
    end else if (match) begin
      n.conf = conf_inc;
      n.quiet = (r.quiet != '0) ? r.quiet - 1'b1 : trigger_o ? loop_range_p'(prefetch_depth_p) : '0;
    end else begin
      n.stride = (r.conf == '0) ? diff : r.stride;
      n.conf = (r.conf == '0) ? '0 : r.conf - 1'b1;
      n.quiet = '0;
    end
  end
endmodule

// File: rtl/bp_be_stride_detector.sv
// bp_be_stride_detector: per-PC stride table feeding one striding-load request to the prefetch generator
module bp_be_stride_detector
  import bp_be_pkg::*;
#(
  parameter int vaddr_width_p = 39,
  parameter int entries_p = 16,
  parameter int loop_range_p = 8,
  parameter int stride_width_p = 8,
  parameter int conf_width_p = 2,
  parameter int conf_thresh_p = 2,
  parameter int prefetch_depth_p = 4
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      flush_i,
  input  logic                      load_v_i,
  input  logic [vaddr_width_p-1:0]  load_pc_i,
  input  logic [vaddr_width_p-1:0]  load_addr_i,
  output logic                      v_o,
  input  logic                      ready_and_i,
  output logic [vaddr_width_p-1:0]  pc_o,
  output logic [vaddr_width_p-1:0]  eff_addr_o,
  output logic [stride_width_p-1:0] stride_o,
  output logic [loop_range_p-1:0]   loop_counter_o
);
  localparam int lg_entries_lp = $clog2(entries_p);
  localparam int tag_width_lp = vaddr_width_p - 2 - lg_entries_lp;
  `DECLARE_BP_BE_STRIDE_ENTRY_S(vaddr_width_p, tag_width_lp, conf_width_p, loop_range_p);
  bp_be_stride_entry_s tbl_r [entries_p];
  bp_be_stride_entry_s entry_n;
  bp_be_stride_reason_e reason;
  logic [lg_entries_lp-1:0] idx;
  logic [tag_width_lp-1:0] tag;
  logic slot_free, qualified, trigger, unused;
  assign idx = load_pc_i[2 +: lg_entries_lp];
  assign tag = load_pc_i[vaddr_width_p-1 -: tag_width_lp];
  assign unused = ^load_pc_i[1:0];
  assign slot_free = ~v_o | ready_and_i;
  assign trigger = load_v_i & qualified;
  bp_be_stride_entry_update #(
    .vaddr_width_p(vaddr_width_p),
    .tag_width_p(tag_width_lp),
    .stride_width_p(stride_width_p),
    .conf_width_p(conf_width_p),
    .conf_thresh_p(conf_thresh_p),
    .loop_range_p(loop_range_p),
    .prefetch_depth_p(prefetch_depth_p)
  ) update (
    .entry_i(tbl_r[idx]),
    .tag_i(tag),
    .addr_i(load_addr_i),
    .slot_free_i(slot_free),
    .entry_o(entry_n),
    .trigger_o(qualified),
    .reason_o(reason)
  );
  always_ff @(posedge clk_i) begin
    if (reset_i | flush_i) begin
      for (int i = 0; i < entries_p; i++) tbl_r[i].v <= 1'b0;
      v_o <= 1'b0;
      pc_o <= '0;
      eff_addr_o <= '0;
      stride_o <= '0;
      loop_counter_o <= '0;
    end else begin
      if (load_v_i) tbl_r[idx] <= entry_n;
      if (trigger) begin
        v_o <= 1'b1;
        pc_o <= load_pc_i;
        eff_addr_o <= load_addr_i;
        stride_o <= entry_n.stride[stride_width_p-1:0];
        loop_counter_o <= loop_range_p'(prefetch_depth_p);
      end else if (ready_and_i) begin
        v_o <= 1'b0;
      end
    end
  end
  always_ff @(posedge clk_i)
    if (!reset_i && !flush_i && trigger) assert (reason == e_stride_issue);
endmodule

// File: tb/tb_bp_be_stride_detector.sv
// tb_bp_be_stride_detector: table vectors, directed corner sequences and random traffic vs a reference model
module tb_bp_be_stride_detector;
  localparam int VW = 39;
  logic clk, reset, flush, load_v, ready;
  logic [VW-1:0] load_pc, load_addr, pc_o, eff_addr_o;
  logic [7:0] stride_o, loop_o;
  logic v_o;
  int n_chk = 0, n_fail = 0;

  bp_be_stride_detector dut (
    .clk_i(clk), .reset_i(reset), .flush_i(flush), .load_v_i(load_v),
    .load_pc_i(load_pc), .load_addr_i(load_addr), .v_o(v_o), .ready_and_i(ready),
    .pc_o(pc_o), .eff_addr_o(eff_addr_o), .stride_o(stride_o), .loop_counter_o(loop_o)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  typedef struct {bit v; logic [VW-1:0] pc; logic [VW-1:0] last; logic [VW-1:0] stride; int conf; int quiet;} ment_t;
  ment_t mt[16];
  bit m_v;
  logic [VW-1:0] m_pc, m_addr;
  logic [7:0] m_stride, m_loop;

  // reference: a PC owns slot pc[5:2] as long as its upper PC bits match
  task automatic model(input bit rst, fl, lv, input logic [VW-1:0] pc, addr, input bit rdy);
    bit free;
    int i;
    logic [VW-1:0] d;
    ment_t e;
    if (rst || fl) begin
      foreach (mt[k]) mt[k].v = 0;
      m_v = 0; m_pc = 0; m_addr = 0; m_stride = 0; m_loop = 0;
      return;
    end
    free = !m_v || rdy;
    if (m_v && rdy) m_v = 0;
    if (!lv) return;
    i = int'(pc[5:2]);
    e = mt[i];
    if (!e.v || (e.pc >> 6) != (pc >> 6)) begin
      e.v = 1; e.pc = pc; e.last = addr; e.stride = 0; e.conf = 0; e.quiet = 0;
      mt[i] = e;
      return;
    end
    d = addr - e.last;
    e.last = addr;
    if (d == e.stride) begin
      e.conf = (e.conf < 3) ? e.conf + 1 : 3;
      if (e.quiet > 0) e.quiet--;
      else if (e.conf >= 2 && $signed(d) > 0 && d < 256 && free) begin
        m_v = 1; m_pc = pc; m_addr = addr; m_stride = d[7:0]; m_loop = 4; e.quiet = 4;
      end
    end else if (e.conf == 0) begin
      e.stride = d; e.quiet = 0;
    end else begin
      e.conf--; e.quiet = 0;
    end
    mt[i] = e;
  endtask

  task automatic chk(input string nm, input logic [63:0] got, exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic step(input bit rst, fl, lv, input logic [VW-1:0] pc, addr, input bit rdy);
    reset = rst; flush = fl; load_v = lv; load_pc = pc; load_addr = addr; ready = rdy;
    @(posedge clk);
    model(rst, fl, lv, pc, addr, rdy);
    #1;
    chk("model_v", v_o, m_v);
    if (m_v) begin
      chk("model_pc", pc_o, m_pc);
      chk("model_addr", eff_addr_o, m_addr);
      chk("model_stride", stride_o, m_stride);
      chk("model_loop", loop_o, m_loop);
    end
  endtask

  task automatic ld(input logic [VW-1:0] pc, addr, input bit rdy);
    step(0, 0, 1, pc, addr, rdy);
  endtask

  task automatic exp_o(input string nm, input bit v, input logic [VW-1:0] pc, addr, input logic [7:0] st);
    chk({nm, "_v"}, v_o, v);
    if (v) begin
      chk({nm, "_pc"}, pc_o, pc);
      chk({nm, "_addr"}, eff_addr_o, addr);
      chk({nm, "_stride"}, stride_o, st);
      chk({nm, "_loop"}, loop_o, 4);
    end
  endtask

  task automatic exp_zero(input string nm);
    chk({nm, "_v"}, v_o, 0);
    chk({nm, "_pc"}, pc_o, 0);
    chk({nm, "_addr"}, eff_addr_o, 0);
    chk({nm, "_stride"}, stride_o, 0);
    chk({nm, "_loop"}, loop_o, 0);
  endtask

  typedef struct {logic [VW-1:0] addr; bit v; logic [VW-1:0] eaddr;} vec_t;
  vec_t vecs[10];
  localparam logic [VW-1:0] A = 39'h80000040, B = 39'h80000084, AL = 39'h80000440;

  initial begin
    logic [VW-1:0] fpc[3], fst[3], rpc[6], rst_[6], raddr[6];
    int k;
    vecs[0] = '{39'h1000, 0, 0}; vecs[1] = '{39'h1008, 0, 0}; vecs[2] = '{39'h1010, 0, 0};
    vecs[3] = '{39'h1018, 1, 39'h1018}; vecs[4] = '{39'h1020, 0, 0}; vecs[5] = '{39'h1028, 0, 0};
    vecs[6] = '{39'h1030, 0, 0}; vecs[7] = '{39'h1038, 0, 0}; vecs[8] = '{39'h1040, 1, 39'h1040};
    vecs[9] = '{39'h1048, 0, 0};
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    exp_zero("reset");
    for (int i = 0; i < 10; i++) begin
      ld(A, vecs[i].addr, 1);
      exp_o($sformatf("train%0d", i), vecs[i].v, A, vecs[i].eaddr, 8);
    end
    // backpressure: second PC's trigger is dropped while A is held, then retried
    step(1, 0, 0, 0, 0, 0);
    foreach (vecs[i]) if (i < 4) ld(A, vecs[i].addr + 39'h1000, 0);
    exp_o("bp_first", 1, A, 39'h2018, 8);
    for (int i = 0; i < 4; i++) ld(B, 39'h3000 + 39'(4 * i), 0);
    exp_o("bp_hold", 1, A, 39'h2018, 8);
    step(0, 0, 0, 0, 0, 1);
    exp_o("bp_drain", 0, 0, 0, 0);
    ld(B, 39'h3010, 1);
    exp_o("bp_retry", 1, B, 39'h3010, 4);
    // negative, too-wide and zero strides never issue
    step(1, 0, 0, 0, 0, 0);
    fpc = '{39'h80000104, 39'h80000108, 39'h8000010c};
    fst = '{39'h0 - 39'h8, 39'h100, 39'h0};
    for (int s = 0; s < 3; s++)
      for (int j = 0; j < 6; j++) begin
        ld(fpc[s], 39'h8000 + fst[s] * 39'(j), 1);
        chk($sformatf("filter%0d_%0d_v", s, j), v_o, 0);
      end
    // mismatch after conf saturates, then an alias evicts the entry
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 9; i++) ld(A, 39'h1000 + 39'(8 * i), 1);
    exp_o("conf3_issue", 1, A, 39'h1040, 8);
    ld(A, 39'h1100, 1);
    exp_o("mismatch", 0, 0, 0, 0);
    ld(A, 39'h1108, 1);
    exp_o("mismatch_reissue", 1, A, 39'h1108, 8);
    ld(AL, 39'h9000, 1);
    exp_o("alias_alloc", 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      ld(A, 39'h1110 + 39'(8 * i), 1);
      chk($sformatf("alias_retrain%0d_v", i), v_o, 0);
    end
    ld(A, 39'h1128, 1);
    exp_o("alias_issue", 1, A, 39'h1128, 8);
    // flush with a held request and a simultaneous load
    step(0, 1, 1, A, 39'h1130, 0);
    exp_o("flush", 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      ld(A, 39'h1138 + 39'(8 * i), 0);
      chk($sformatf("flush_miss%0d_v", i), v_o, 0);
    end
    ld(A, 39'h1150, 0);
    exp_o("flush_reissue", 1, A, 39'h1150, 8);
    step(1, 0, 1, A, 39'h1158, 0);
    exp_zero("reset_mid");
    for (int i = 0; i < 4; i++) ld(A, 39'h1000 + 39'(8 * i), 0);
    exp_o("pre_rstflush", 1, A, 39'h1018, 8);
    step(1, 1, 1, A, 39'h1020, 0);
    exp_zero("reset_flush");
    // random traffic against the model
    rpc = '{A, AL, B, 39'h80000108, 39'h8000010c, 39'h80000110};
    rst_ = '{39'h8, 39'h8, 39'h4, 39'h0 - 39'h8, 39'h100, 39'h0};
    foreach (raddr[i]) raddr[i] = 39'h40000 * 39'(i + 1);
    for (int c = 0; c < 3000; c++) begin
      k = int'($urandom_range(0, 5));
      if ($urandom_range(0, 15) == 0) raddr[k] = {7'd0, $urandom()};
      else raddr[k] = raddr[k] + rst_[k];
      step(0, $urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, rpc[k], raddr[k],
           $urandom_range(0, 3) != 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
